interleaver_tx: RTL and testbench
=================================

// Module: interleaver_tx
// PURPOSE
// - Transmit-side 802.11a block interleaver: serial coded bits in, permuted subcarrier bit groups out.
// - Sits between the convolutional encoder/puncturer and the constellation mapper.
// - Ping-pong buffered: one OFDM symbol fills while the previous one drains.
// - Standard two-step permutation over Ncbps = 48/96/192/288, Nbpsc = 1/2/4/6.
// PARAMETERS
// - NCBPS_MAX  288  size of each buffer bank in bits (fixed by 64-QAM)
// - NBPSC_MAX  6    output group width in bits
// PORTS
// - clk        in   1  rising-edge clock, the only clock
// - reset      in   1  asynchronous, active-low reset
// - clr        in   1  synchronous flush: empties both banks and zeroes all counters
// - mod_sel    in   2  0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled with the first bit of each symbol
// - in_valid   in   1  in_bit is valid
// - in_ready   out  1  interleaver can accept in_bit
// - in_bit     in   1  coded bit, symbol order k = 0..Ncbps-1
// - out_valid  out  1  out_data holds one subcarrier group
// - out_ready  in   1  mapper accepts out_data
// - out_data   out  6  Nbpsc bits, LSB-aligned; bit 0 = lowest interleaved index j; unused MSBs 0
// - out_nbpsc  out  3  Nbpsc of the symbol currently draining (1/2/4/6)
// - out_last   out  1  asserted with the final group of a symbol (beat Ncbps/Nbpsc-1)
// BEHAVIOUR
// - Reset / clr: both bank_full = 0, wr_bank = rd_bank = 0, k = 0, read pointer = 0.
//   Outputs: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, out_nbpsc = 1.
// - Rate table: (Ncbps, Nbpsc, s) = (48,1,1), (96,2,1), (192,4,2), (288,6,3); s = max(Nbpsc/2, 1).
// - Write side:
//   - An input beat is accepted when in_valid && in_ready; in_ready = !bank_full[wr_bank].
//   - At k = 0, mod_sel is latched into bank_mod[wr_bank]; it holds for the whole symbol.
//   - Counters: col = k mod 16, row = k / 16.
//   - i = (Ncbps/16)*col + row; floor(16i/Ncbps) = col exactly, so no divider is needed.
//   - j = s*floor(i/s) + (i + Ncbps - col) mod s. Division is by 1/2/3 only (small constant logic).
//   - The accepted bit is stored at bank[wr_bank][j].
//   - On the bit where k = Ncbps-1: bank_full[wr_bank] <= 1, wr_bank toggles, k <= 0.
// - Read side:
//   - out_valid = bank_full[rd_bank], registered.
//   - out_data = bank[rd_bank][p +: Nbpsc], zero-extended to 6 bits.
//   - On out_valid && out_ready, p advances by Nbpsc.
//   - On the last beat (out_last): bank_full[rd_bank] <= 0, rd_bank toggles, p <= 0.
//   - out_data, out_nbpsc and out_last stay stable while out_valid && !out_ready.
// - Latency: out_valid rises 1 cycle after the last bit of a symbol is accepted, provided that bank was free to drain.
// - Throughput: 1 bit/cycle in; Nbpsc bits/cycle out. With out_ready held high, in_ready never drops.
// - Simultaneous events:
//   - Filling one bank and emptying the other in the same cycle are independent and both take effect.
//   - If both banks are full, in_ready = 0 until the draining bank's last beat. in_ready rises the cycle after that beat.
//   - The rate may change per symbol. Each bank uses its own latched bank_mod.
// - clr or reset mid-symbol discards all partial and full symbols. There is no partial output.
// - mod_sel changing while k != 0 has no effect.
// STRUCTURE
// - Shared package wlan_pkg:
//   - mod_t enum (BPSK/QPSK/QAM16/QAM64)
//   - functions ncbps_of(mod), nbpsc_of(mod), s_of(mod)
//   - constant NCBPS_MAX = 288
// - One sub-module, interleaver_addr_gen: combinational (mod, col, row) -> j.
//   - Reused by the receive side with the inverse mapping.
// - Top level holds the two 288-bit banks, the write/read counters and the bank_full flags.
// TESTING
// - BPSK, only k=1 set in a 48-bit symbol -> out_data = 1 on beat 3 only; out_last on beat 47.
// - 16-QAM, only k=1 set -> j = 13: beat 3 out_data = 6'b000010; 48 beats total.
// - 64-QAM, only k=1 set -> j = 20: beat 3 out_data = 6'b000100; 48 beats total.
// - out_ready = 0 while two symbols are streamed:
//   - in_ready drops after bit 575; out_data stays stable.
//   - Releasing out_ready drains 2x48 beats in order.
//   - in_ready rises the cycle after the first out_last.
// - Back-to-back symbols BPSK then 64-QAM with out_ready = 1:
//   - in_ready never drops.
//   - out_nbpsc = 1 for symbol 0, then 6 for symbol 1.
//   - Data matches the golden model.
// - Assert clr (and, separately, reset) at k = 100 with one symbol full:
//   - out_valid = 0 the next cycle; in_ready = 1.
//   - A new symbol then interleaves correctly.

Source files
------------

// File: rtl/wlan_pkg.sv
// Shared 802.11a constants and per-modulation rate helpers.
// Used by the transmit interleaver and its address generator.
package wlan_pkg;

  localparam int NCBPS_MAX = 288;
  localparam int NBPSC_MAX = 6;

  typedef enum logic [1:0] {
    BPSK  = 2'd0,
    QPSK  = 2'd1,
    QAM16 = 2'd2,
    QAM64 = 2'd3
  } mod_t;

  function automatic logic [8:0] ncbps_of(mod_t m);
    case (m)
      BPSK:    return 9'd48;
      QPSK:    return 9'd96;
      QAM16:   return 9'd192;
      default: return 9'd288;
    endcase
  endfunction

  function automatic logic [2:0] nbpsc_of(mod_t m);
    case (m)
      BPSK:    return 3'd1;
      QPSK:    return 3'd2;
      QAM16:   return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic [1:0] s_of(mod_t m);
    case (m)
      QAM16:   return 2'd2;
      QAM64:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [NBPSC_MAX-1:0] grp_mask(mod_t m);
    case (m)
      BPSK:    return 6'h01;
      QPSK:    return 6'h03;
      QAM16:   return 6'h0F;
      default: return 6'h3F;
    endcase
  endfunction

endpackage

// File: rtl/interleaver_addr_gen.sv
// Combinational two-step interleaver permutation: (mod, col, row) -> j.
// i = (Ncbps/16)*col + row; the second step only needs i/s and i mod s for s in 1..3.
module interleaver_addr_gen
  import wlan_pkg::*;
(
  input  mod_t       mod_i,
  input  logic [3:0] col_i,
  input  logic [4:0] row_i,
  output logic [8:0] j_o
);

  logic [8:0] i_w;
  logic [1:0] row_m3;
  logic [1:0] col_m3;
  logic [2:0] rot3;

  always_comb begin
    i_w    = (ncbps_of(mod_i) >> 4) * {5'd0, col_i} + {4'd0, row_i};
    row_m3 = 2'(row_i % 5'd3);
    col_m3 = 2'(col_i % 4'd3);
    // (row - col) mod 3; 18*col is a multiple of 3 so i mod 3 == row mod 3
    rot3   = {1'b0, row_m3} + 3'd3 - {1'b0, col_m3};
    if (rot3 >= 3'd3) rot3 = rot3 - 3'd3;
    case (s_of(mod_i))
      2'd2:    j_o = {i_w[8:1], i_w[0] ^ col_i[0]};
      2'd3:    j_o = i_w - {7'd0, row_m3} + {7'd0, rot3[1:0]};
      default: j_o = i_w;
    endcase
  end

endmodule

// File: rtl/interleaver_tx.sv
// Ping-pong 802.11a transmit interleaver: bits are scattered into one bank by
// permuted address while the other bank drains Nbpsc-bit groups in order.
module interleaver_tx
  import wlan_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [1:0]           mod_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBPSC_MAX-1:0] out_data,
  output logic [2:0]           out_nbpsc,
  output logic                 out_last
);

  logic [NCBPS_MAX-1:0] bank_q [2];
  mod_t                 mod_q [2];
  mod_t                 mod_d [2];
  logic [1:0]           full_q, full_d;
  logic                 wr_q, wr_d, rd_q, rd_d;
  logic [8:0]           k_q, k_d, p_q, p_d;
  mod_t                 wr_mod, rd_mod;
  logic [8:0]           j_w;
  logic                 accept, wr_last, rd_fire;
  logic [NBPSC_MAX-1:0] rd_grp;

  // The first bit of a symbol uses mod_sel directly; later bits use the latched rate.
  assign wr_mod   = (k_q == 9'd0) ? mod_t'(mod_sel) : mod_q[wr_q];
  assign in_ready = !full_q[wr_q];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (k_q == ncbps_of(wr_mod) - 9'd1);

  interleaver_addr_gen u_addr (
    .mod_i (wr_mod),
    .col_i (k_q[3:0]),
    .row_i (k_q[8:4]),
    .j_o   (j_w)
  );

  assign rd_mod    = mod_q[rd_q];
  assign out_valid = full_q[rd_q];
  assign out_nbpsc = nbpsc_of(rd_mod);
  assign out_last  = out_valid && ((p_q + 9'(out_nbpsc)) == ncbps_of(rd_mod));
  assign rd_grp    = 6'(bank_q[rd_q] >> p_q);
  assign out_data  = out_valid ? (rd_grp & grp_mask(rd_mod)) : '0;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    k_d    = k_q;
    p_d    = p_q;
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    mod_d  = mod_q;
    if (accept) begin
      if (k_q == 9'd0) mod_d[wr_q] = mod_t'(mod_sel);
      if (wr_last) begin
        full_d[wr_q] = 1'b1;
        wr_d         = !wr_q;
        k_d          = 9'd0;
      end else begin
        k_d = k_q + 9'd1;
      end
    end
    // A bank cannot be filling and draining at once, so both updates are independent.
    if (rd_fire) begin
      if (out_last) begin
        full_d[rd_q] = 1'b0;
        rd_d         = !rd_q;
        p_d          = 9'd0;
      end else begin
        p_d = p_q + 9'(out_nbpsc);
      end
    end
    if (clr) begin
      k_d      = 9'd0;
      p_d      = 9'd0;
      full_d   = 2'b00;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      mod_d[0] = BPSK;
      mod_d[1] = BPSK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q      <= 9'd0;
      p_q      <= 9'd0;
      full_q   <= 2'b00;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mod_q[0] <= BPSK;
      mod_q[1] <= BPSK;
    end else begin
      k_q    <= k_d;
      p_q    <= p_d;
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      mod_q  <= mod_d;
    end
  end

  // Bank contents need no reset: every address of a symbol is written exactly once.
  always_ff @(posedge clk) begin
    if (accept) bank_q[wr_q][j_w] <= in_bit;
  end

endmodule

// File: tb/tb_interleaver_tx.sv
// Scoreboard bench for interleaver_tx with a formula-level permutation model.
module tb_interleaver_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mod_sel = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last;
  logic [5:0] out_data;
  logic [2:0] out_nbpsc;

  always #5 clk = ~clk;

  interleaver_tx dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .mod_sel   (mod_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbpsc (out_nbpsc),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [5:0] data;
    logic [2:0] nb;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t rx_log[$];
  int    checks = 0;
  int    failures = 0;
  int    stall_cnt = 0;
  int    rdy_mode = 1;
  bit    sym_bits[288];
  int    NCB[4] = '{48, 96, 192, 288};
  int    NB[4]  = '{1, 2, 4, 6};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  // Reference: scatter bits by the standard two-step formula, then slice in order.
  task automatic push_model(input int m);
    int n, nb, s, i, j;
    bit ob[288];
    n  = NCB[m];
    nb = NB[m];
    s  = (nb / 2 > 1) ? nb / 2 : 1;
    for (int k = 0; k < n; k++) begin
      i = (n / 16) * (k % 16) + k / 16;
      j = s * (i / s) + (i + n - (16 * i) / n) % s;
      ob[j] = sym_bits[k];
    end
    for (int b = 0; b < n / nb; b++) begin
      beat_t e;
      e = '0;
      for (int t = 0; t < nb; t++) e.data[t] = ob[b * nb + t];
      e.nb   = 3'(nb);
      e.last = (b == n / nb - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  beat_t prev;
  bit    prev_stall = 1'b0;

  always @(negedge clk) begin
    beat_t cur, e;
    cur = {out_data, out_nbpsc, out_last};
    if (reset && out_valid) begin
      if (prev_stall) begin
        check("hold_data", 32'(cur.data), 32'(prev.data));
        check("hold_nbpsc", 32'(cur.nb), 32'(prev.nb));
        check("hold_last", 32'(cur.last), 32'(prev.last));
      end
      if (out_ready) begin
        rx_log.push_back(cur);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got data=%0h nbpsc=%0d expected no beat", cur.data, cur.nb);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(cur.data), 32'(e.data));
          check("beat_nbpsc", 32'(cur.nb), 32'(e.nb));
          check("beat_last", 32'(cur.last), 32'(e.last));
        end
      end
      prev       = cur;
      prev_stall = !out_ready;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_bit(input logic b, input logic [1:0] m, output bit timeout);
    int guard;
    guard   = 0;
    timeout = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    mod_sel  = m;
    while (!in_ready) begin
      stall_cnt++;
      guard++;
      if (guard > 4000) begin
        timeout  = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // pat 1 = only k=1 set; mod_sel is scrambled after the first bit.
  task automatic send_symbol(input int m, input int pat, input int nbits, input bit gaps);
    bit to;
    for (int k = 0; k < NCB[m]; k++)
      sym_bits[k] = (pat == 1) ? (k == 1) : 1'($urandom_range(0, 1));
    if (nbits == NCB[m]) push_model(m);
    for (int k = 0; k < nbits; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send_bit(sym_bits[k], (k == 0) ? 2'(m) : 2'($urandom_range(0, 3)), to);
      if (to) begin
        checks++;
        failures++;
        $display("FAIL in_accept_timeout got in_ready=0 at k=%0d expected acceptance", k);
        return;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input int m, input string name, input logic [5:0] beat3);
    int nz;
    rx_log.delete();
    send_symbol(m, 1, NCB[m], 1'b0);
    wait_drain({name, "_drain"});
    check({name, "_beats"}, 32'(rx_log.size()), 32'd48);
    if (rx_log.size() == 48) begin
      nz = 0;
      foreach (rx_log[b]) if (rx_log[b].data != 6'd0) nz++;
      check({name, "_beat3"}, 32'(rx_log[3].data), 32'(beat3));
      check({name, "_nonzero"}, 32'(nz), 32'd1);
      check({name, "_last47"}, 32'(rx_log[47].last), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_nbpsc", 32'(out_nbpsc), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    directed(0, "bpsk_k1", 6'b000001);
    directed(2, "qam16_k1", 6'b000010);
    directed(3, "qam64_k1", 6'b000100);

    // Two symbols against a stalled mapper.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rx_log.delete();
    stall_cnt = 0;
    send_symbol(3, 0, 288, 1'b0);
    send_symbol(3, 0, 288, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_no_stall", 32'(stall_cnt), 32'd0);
    repeat (8) @(negedge clk);
    rdy_mode = 1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        found = 1'b1;
        check("bp_in_ready_before", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL bp_first_last got none expected out_last within 200 cycles");
    end
    wait_drain("bp_drain");
    check("bp_beats", 32'(rx_log.size()), 32'd96);

    // BPSK then 64-QAM back to back.
    rx_log.delete();
    stall_cnt = 0;
    send_symbol(0, 0, 48, 1'b0);
    send_symbol(3, 0, 288, 1'b0);
    check("b2b_no_stall", 32'(stall_cnt), 32'd0);
    wait_drain("b2b_drain");
    check("b2b_beats", 32'(rx_log.size()), 32'd96);
    if (rx_log.size() == 96) begin
      check("b2b_nbpsc0", 32'(rx_log[0].nb), 32'd1);
      check("b2b_nbpsc1", 32'(rx_log[48].nb), 32'd6);
    end

    // Random rates, input gaps and output backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 6; n++) begin
      int m;
      m = $urandom_range(0, 3);
      send_symbol(m, 0, NCB[m], 1'b1);
    end
    wait_drain("rand_drain");
    rdy_mode = 1;

    // clr at k=100 with one symbol full.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send_symbol(1, 0, 96, 1'b0);
    send_symbol(3, 0, 100, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clr = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    rdy_mode = 1;
    send_symbol(2, 0, 192, 1'b0);
    wait_drain("clr_after");

    // Reset at k=100 with one symbol full.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send_symbol(0, 0, 48, 1'b0);
    send_symbol(3, 0, 100, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    send_symbol(3, 0, 288, 1'b0);
    wait_drain("rst2_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
